// File: rtl/uart_avmm_pkg.sv
// uart_avmm_pkg: frame opcodes, response bytes and the FSM state type shared
// by the UART-to-Avalon-MM master and its bench.
package uart_avmm_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
  localparam logic [7:0] OP_RD   = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    WDATA,
    BUS_WR,
    BUS_RD,
    RD_WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/uart_avmm_master_if.sv
// uart_avmm_master_if: UART byte streams, status flags and the Avalon-MM
// master bus of uart_avmm_master, bundled into one interface.
//
// Handshakes:
//   rx  : rx_valid is a one-cycle strobe; there is no ready, so a byte that
//         arrives while the master is busy is lost.
//   tx  : a byte moves on a cycle with tx_valid & tx_ready; tx_valid/tx_data
//         hold until that cycle, tx_valid never drops without a transfer.
//   avm : a request (avm_read or avm_write) is accepted on a cycle with
//         avm_waitrequest low; address/data hold while it is high. Read data
//         comes back on a later cycle qualified by avm_readdatavalid.
interface uart_avmm_master_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              frame_err;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic              avm_readdatavalid;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid,
    output tx_data, tx_valid, busy, frame_err,
    output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    output avm_readdata, avm_waitrequest, avm_readdatavalid,
    input  tx_data, tx_valid, busy, frame_err,
    input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
  );
endinterface

// File: rtl/uart_avmm_timer.sv
// uart_avmm_timer: inter-byte gap counter. Cleared by load (a received byte)
// or whenever tick is low; expire is high on the CYCLES-th consecutive ticking
// cycle without a load. Only instantiated when UART_AVMM_TIMEOUT_EN is defined.
module uart_avmm_timer #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expire
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] count;

  assign expire = tick && !load && (count == CW'(CYCLES - 1));

  // Count idle ticking cycles; any byte or leaving the frame restarts from 0.
  always_ff @(posedge clk) begin
    if (reset || load || !tick) begin
      count <= '0;
    end else if (!expire) begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/uart_avmm_master.sv
// uart_avmm_master: decodes 'W'/'R' byte frames from the UART, runs exactly
// one Avalon-MM word transaction per frame and streams the response back.
// Optional inter-byte timeout abort: define UART_AVMM_TIMEOUT_EN.
module uart_avmm_master
  import uart_avmm_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  uart_avmm_master_if.master bus,
  output state_t             state
);
  logic        is_rd;      // frame opcode was 'R'
  logic [1:0]  wcnt;       // write-data byte index
  logic [7:0]  addr_hi;    // first address byte, held until the second
  logic [23:0] rdata_hi;   // read-data bytes 1..3 still to be sent
  logic [1:0]  resp_left;  // response bytes remaining after the current one
  logic        timeout;

  assign bus.avm_byteenable = 4'hF;

`ifdef UART_AVMM_TIMEOUT_EN
  logic in_frame;
  assign in_frame = (state == ADDR_HI) || (state == ADDR_LO) || (state == WDATA);

  uart_avmm_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (bus.rx_valid),
    .tick   (in_frame),
    .expire (timeout)
  );
`else
  assign timeout = 1'b0;
  // No gap counter in this build; the parameter is kept for a uniform port list.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Frame parser, bus sequencer and response streamer; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      is_rd             <= 1'b0;
      wcnt              <= 2'd0;
      addr_hi           <= 8'h00;
      rdata_hi          <= 24'h0;
      resp_left         <= 2'd0;
      bus.avm_read      <= 1'b0;
      bus.avm_write     <= 1'b0;
      bus.avm_address   <= '0;
      bus.avm_writedata <= 32'h0;
      bus.tx_valid      <= 1'b0;
      bus.tx_data       <= 8'h00;
      bus.busy          <= 1'b0;
      bus.frame_err     <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == OP_WR || bus.rx_data == OP_RD) begin
              is_rd <= (bus.rx_data == OP_RD);
              state <= ADDR_HI;
            end else begin
              bus.frame_err <= 1'b1;
              bus.tx_data   <= RSP_ERR;
              bus.tx_valid  <= 1'b1;
              resp_left     <= 2'd0;
              bus.busy      <= 1'b1;
              state         <= RESP;
            end
          end
        end
        ADDR_HI: begin
          if (timeout) begin
            bus.frame_err <= 1'b1;
            state         <= IDLE;
          end else if (bus.rx_valid) begin
            addr_hi <= bus.rx_data;
            state   <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (timeout) begin
            bus.frame_err <= 1'b1;
            state         <= IDLE;
          end else if (bus.rx_valid) begin
            bus.avm_address <= ADDR_W'({addr_hi, bus.rx_data});
            if (is_rd) begin
              bus.avm_read <= 1'b1;
              bus.busy     <= 1'b1;
              state        <= BUS_RD;
            end else begin
              wcnt  <= 2'd0;
              state <= WDATA;
            end
          end
        end
        WDATA: begin
          if (timeout) begin
            bus.frame_err <= 1'b1;
            state         <= IDLE;
          end else if (bus.rx_valid) begin
            // LSB arrives first, so shift new bytes in from the top.
            bus.avm_writedata <= {bus.rx_data, bus.avm_writedata[31:8]};
            wcnt              <= wcnt + 2'd1;
            if (wcnt == 2'd3) begin
              bus.avm_write <= 1'b1;
              bus.busy      <= 1'b1;
              state         <= BUS_WR;
            end
          end
        end
        BUS_WR: begin
          if (!bus.avm_waitrequest) begin
            bus.avm_write <= 1'b0;
            bus.tx_data   <= RSP_OK;
            bus.tx_valid  <= 1'b1;
            resp_left     <= 2'd0;
            state         <= RESP;
          end
        end
        BUS_RD: begin
          if (!bus.avm_waitrequest) begin
            bus.avm_read <= 1'b0;
            state        <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.avm_readdatavalid) begin
            bus.tx_data  <= bus.avm_readdata[7:0];
            rdata_hi     <= bus.avm_readdata[31:8];
            bus.tx_valid <= 1'b1;
            resp_left    <= 2'd3;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.tx_ready) begin
            if (resp_left == 2'd0) begin
              bus.tx_valid <= 1'b0;
              bus.busy     <= 1'b0;
              state        <= IDLE;
            end else begin
              bus.tx_data <= rdata_hi[7:0];
              rdata_hi    <= {8'h00, rdata_hi[23:8]};
              resp_left   <= resp_left - 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_avmm_master.sv
// tb_uart_avmm_master: directed vector table, hand-written corner sequences
// and randomized frames against a memory-level reference model.
module tb_uart_avmm_master;
  import uart_avmm_pkg::*;

  localparam int ADDR_W = 16;
`ifdef UART_AVMM_TIMEOUT_EN
  localparam int TO_CYC = 100;
`else
  localparam int TO_CYC = 500000;
`endif

  typedef struct {
    logic [6:0][7:0] frm;      // frame bytes, element 0 sent first
    int              n;
    logic [3:0][7:0] rsp;      // response bytes, element 0 first
    int              nrsp;
    bit              has_bus;
    logic [48:0]     op;       // {is_write, address, writedata (0 for reads)}
    bit              ferr;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t state;

  uart_avmm_master_if #(.ADDR_W(ADDR_W)) bus ();

  uart_avmm_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [8:0]  exp_q[$];        // {last_of_frame, byte}
  logic [48:0] exp_bus_q[$];
  logic [31:0] slave_mem[int];  // the RAM slave contents
  logic [31:0] ref_mem[int];    // reference model's view of memory
  vec_t        vtab[$];

  int stall_left = 0, stall_pct = 0, rd_lat_max = 1, rdy_low_cnt = 0;
  bit rdy_random = 1'b0;
  int ferr_seen = 0, ferr_exp = 0, xfer_cnt = 0, req_cycles = 0, acc_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor + slave + tx_ready driver ----------------
  logic              acc_wr, acc_rd, req_pend, tx_pend, busy_chk, ferr_prev;
  logic [49:0]       pend_req;
  logic [7:0]        tx_pend_data;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_data, rd_word;
  logic [48:0]       e_op;
  logic [8:0]        e_b;
  int                rd_cnt;

  initial begin
    bus.tx_ready = 1'b1;
    bus.avm_readdata = 32'h0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    req_pend = 1'b0; tx_pend = 1'b0; busy_chk = 1'b0; ferr_prev = 1'b0;
    rd_cnt = 0; rd_word = 32'h0;
    forever begin
      @(negedge clk);
      acc_wr = 1'b0;
      acc_rd = 1'b0;
      if (reset) begin
        req_pend = 1'b0; tx_pend = 1'b0; busy_chk = 1'b0; ferr_prev = 1'b0;
      end else begin
        if (req_pend)
          check("req_stable", 64'({bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata}), 64'(pend_req));
        if (bus.avm_write || bus.avm_read) req_cycles++;
        acc_wr = bus.avm_write && !bus.avm_waitrequest;
        acc_rd = bus.avm_read && !bus.avm_waitrequest;
        acc_addr = bus.avm_address;
        acc_data = bus.avm_writedata;
        if (acc_wr || acc_rd) begin
          acc_count++;
          if (exp_bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: got request at %0h, expected none", acc_addr);
          end else begin
            e_op = exp_bus_q.pop_front();
            check("bus_op", 64'({acc_wr, acc_addr, acc_wr ? acc_data : 32'h0}), 64'(e_op));
            check("byteenable", 64'(bus.avm_byteenable), 64'hF);
          end
        end
        req_pend = (bus.avm_write || bus.avm_read) && bus.avm_waitrequest;
        pend_req = {bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata};

        if (tx_pend) check("tx_stable", 64'({bus.tx_valid, bus.tx_data}), 64'({1'b1, tx_pend_data}));
        if (busy_chk) begin
          check("busy_after_resp", 64'(bus.busy), 64'(0));
          busy_chk = 1'b0;
        end
        if (bus.tx_valid && bus.tx_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: got byte %0h, expected none", bus.tx_data);
          end else begin
            e_b = exp_q.pop_front();
            check("tx_byte", 64'(bus.tx_data), 64'(e_b[7:0]));
            if (e_b[8]) busy_chk = 1'b1;
          end
        end
        tx_pend = bus.tx_valid && !bus.tx_ready;
        tx_pend_data = bus.tx_data;

        if (bus.frame_err) begin
          ferr_seen++;
          if (ferr_prev) begin
            checks++; errors++;
            $display("FAIL frame_err_width: got 2+ cycle pulse, expected 1 cycle");
          end
        end
        ferr_prev = bus.frame_err;
      end

      @(posedge clk);
      #1;
      if (reset) begin
        rd_cnt = 0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.tx_ready = 1'b1;
      end else begin
        if (acc_wr) slave_mem[int'(acc_addr)] = acc_data;
        if (acc_rd) begin
          rd_word = slave_mem.exists(int'(acc_addr)) ? slave_mem[int'(acc_addr)] : 32'h0;
          rd_cnt = $urandom_range(1, rd_lat_max);
        end
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata = $urandom;  // garbage unless qualified
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata = rd_word;
          end
        end
        if ((bus.avm_write || bus.avm_read) && stall_left > 0) begin
          bus.avm_waitrequest = 1'b1;
          stall_left--;
        end else if (bus.avm_write || bus.avm_read) begin
          bus.avm_waitrequest = ($urandom_range(0, 99) < stall_pct);
        end else begin
          bus.avm_waitrequest = 1'b0;
        end
        if (rdy_low_cnt > 0) begin
          bus.tx_ready = 1'b0;
          rdy_low_cnt--;
        end else begin
          bus.tx_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    step(1);
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask

  task automatic send_frame(input vec_t v, input int gap);
    for (int i = 0; i < v.n; i++) begin
      send_byte(v.frm[i]);
      if (i < v.n - 1) step($urandom_range(0, gap));
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(bus.busy), 64'(0));
    step(1);
  endtask

  task automatic push_exp(input vec_t v);
    for (int i = 0; i < v.nrsp; i++) exp_q.push_back({(i == v.nrsp - 1), v.rsp[i]});
    if (v.has_bus) exp_bus_q.push_back(v.op);
    if (v.ferr) ferr_exp++;
  endtask

  task automatic apply_vec(input vec_t v, input int gap);
    push_exp(v);
    send_frame(v, gap);
    wait_idle("frame_done");
    check("rsp_pending", 64'(exp_q.size()), 64'(0));
    check("bus_pending", 64'(exp_bus_q.size()), 64'(0));
    check("frame_err_count", 64'(ferr_seen), 64'(ferr_exp));
  endtask

  function automatic vec_t mk_vec(input logic [55:0] frm, input int n, input logic [31:0] rsp,
                                  input int nrsp, input bit has_bus, input logic [48:0] op, input bit ferr);
    vec_t v;
    v.frm = frm; v.n = n; v.rsp = rsp; v.nrsp = nrsp;
    v.has_bus = has_bus; v.op = op; v.ferr = ferr;
    return v;
  endfunction

  function automatic vec_t model_wr(input logic [15:0] a, input logic [31:0] d);
    return mk_vec({d, a[7:0], a[15:8], OP_WR}, 7, 32'(RSP_OK), 1, 1'b1, {1'b1, a, d}, 1'b0);
  endfunction

  function automatic vec_t model_rd(input logic [15:0] a, input logic [31:0] d);
    return mk_vec({24'h0, a[7:0], a[15:8], OP_RD}, 3, d, 4, 1'b1, {1'b0, a, 32'h0}, 1'b0);
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within 50000 cycles");
    $display("Simulation finished: %0d checks, %0d errors", checks + 1, errors + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    vec_t        v;
    logic [15:0] a;
    logic [31:0] d;
    logic [7:0]  op;
    int          base, kind, k;

    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    step(3);
    @(negedge clk);
    check("rst_avm_read", 64'(bus.avm_read), 64'(0));
    check("rst_avm_write", 64'(bus.avm_write), 64'(0));
    check("rst_avm_address", 64'(bus.avm_address), 64'(0));
    check("rst_avm_writedata", 64'(bus.avm_writedata), 64'(0));
    check("rst_tx_valid", 64'(bus.tx_valid), 64'(0));
    check("rst_tx_data", 64'(bus.tx_data), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_frame_err", 64'(bus.frame_err), 64'(0));
    check("rst_state", 64'(state), 64'(IDLE));
    check("rst_byteenable", 64'(bus.avm_byteenable), 64'hF);
    step(1);
    reset = 1'b0;
    step(2);

    // Directed vector table: frames written with byte 0 in the low bits.
    vtab.push_back(model_wr(16'h0010, 32'hDEADBEEF));                 // 57 00 10 EF BE AD DE
    vtab.push_back(model_rd(16'h0010, 32'hDEADBEEF));                 // 52 00 10
    vtab.push_back(mk_vec(56'h41, 1, 32'(RSP_ERR), 1, 1'b0, 49'h0, 1'b1));  // bad opcode 'A'
    vtab.push_back(model_rd(16'h0010, 32'hDEADBEEF));                 // normal after error
    vtab.push_back(model_wr(16'hFFFF, 32'h12345678));                 // top address
    vtab.push_back(model_rd(16'hFFFF, 32'h12345678));
    vtab.push_back(model_rd(16'h1234, 32'h00000000));                 // never written
    vtab.push_back(model_wr(16'h0000, 32'h00000001));                 // bottom address
    vtab.push_back(model_rd(16'h0000, 32'h00000001));
    for (int i = 0; i < vtab.size(); i++) apply_vec(vtab[i], 2);

    // Write stalled 5 cycles: request visible 6 cycles, one acceptance.
    base = req_cycles;
    k = acc_count;
    stall_left = 5;
    apply_vec(model_wr(16'h0020, 32'hCAFEF00D), 0);
    check("stall_req_cycles", 64'(req_cycles - base), 64'(6));
    check("stall_accepts", 64'(acc_count - k), 64'(1));

    // Backpressure mid read response, plus a stray byte while busy.
    push_exp(model_rd(16'h0020, 32'hCAFEF00D));
    send_frame(model_rd(16'h0020, 32'hCAFEF00D), 0);
    base = xfer_cnt;
    k = 0;
    while (xfer_cnt == base && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("bp_first_byte", 64'(xfer_cnt != base), 64'(1));
    rdy_low_cnt = 3;
    step(1);
    send_byte(OP_WR);
    wait_idle("bp_done");
    check("bp_rsp_pending", 64'(exp_q.size()), 64'(0));
    apply_vec(model_rd(16'h0010, 32'hDEADBEEF), 1);

    // Reset while a write is stalled: request and response are dropped.
    stall_left = 20;
    send_frame(model_wr(16'h0030, 32'h0BADF00D), 0);
    step(2);
    @(negedge clk);
    check("pre_rst_write", 64'(bus.avm_write), 64'(1));
    step(1);
    reset = 1'b1;
    step(2);
    @(negedge clk);
    check("mid_rst_write", 64'(bus.avm_write), 64'(0));
    check("mid_rst_tx_valid", 64'(bus.tx_valid), 64'(0));
    check("mid_rst_state", 64'(state), 64'(IDLE));
    stall_left = 0;
    step(1);
    reset = 1'b0;
    step(3);
    check("rst_drop_no_tx", 64'(exp_q.size()), 64'(0));
    apply_vec(model_rd(16'h0030, 32'h00000000), 1);

`ifdef UART_AVMM_TIMEOUT_EN
    // Partial frame then silence: abort with one frame_err, no bus, no tx.
    base = req_cycles;
    k = ferr_seen;
    send_byte(OP_WR);
    send_byte(8'h00);
    repeat (90) @(negedge clk);
    check("timeout_early", 64'(ferr_seen - k), 64'(0));
    repeat (20) @(negedge clk);
    check("timeout_ferr", 64'(ferr_seen - k), 64'(1));
    check("timeout_no_bus", 64'(req_cycles - base), 64'(0));
    check("timeout_state", 64'(state), 64'(IDLE));
    ferr_exp++;
    step(1);
    apply_vec(model_rd(16'h0000, 32'h00000001), 0);
`endif

    // Randomized frames against the memory-level reference model.
    for (int r = 0; r < 40; r++) begin
      stall_pct = $urandom_range(0, 60);
      rd_lat_max = $urandom_range(1, 4);
      rdy_random = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      a = 16'h0100 + 16'($urandom_range(0, 7));
      d = $urandom;
      if (kind == 0) begin
        do op = 8'($urandom); while (op == OP_WR || op == OP_RD);
        v = mk_vec({48'h0, op}, 1, 32'(RSP_ERR), 1, 1'b0, 49'h0, 1'b1);
      end else if (kind <= 4) begin
        ref_mem[int'(a)] = d;
        v = model_wr(a, d);
      end else begin
        v = model_rd(a, ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0);
      end
      apply_vec(v, 3);
    end

    rdy_random = 1'b0;
    stall_pct = 0;
    step(5);
    check("final_tx_queue", 64'(exp_q.size()), 64'(0));
    check("final_bus_queue", 64'(exp_bus_q.size()), 64'(0));
    check("final_frame_err", 64'(ferr_seen), 64'(ferr_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
